// File: rtl/tick_timer.sv
// tick_timer: turns rising edges of a divided clock (slowClock, sampled as
// asynchronous data) into one-cycle ticks in the sourceClock domain, and counts
// those ticks in a programmable down-counter. Supports one-shot and periodic
// modes. Expiry is reported as a one-cycle pulse plus a sticky flag.
//
// Optional build macro: TICK_TIMER_MISSED_EN
//   When defined, adds an 8-bit saturating missedCount output. It counts
//   expiries that occur while expiredFlag is still set and unacknowledged.
//
// SYNC_STAGES must be 2 or 3.
module tick_timer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sourceClock,
    input  logic             reset,
    input  logic             slowClock,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             ack,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             expiredFlag
`ifdef TICK_TIMER_MISSED_EN
    ,
    output logic [7:0]       missedCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Synchroniser, edge-detect delay flop and registered tick
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   delay_r;
    logic                   tick_r;

    // Control/datapath state
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WIDTH-1:0]       count_r;
    logic [WIDTH-1:0]       count_nxt_s;
    logic [WIDTH-1:0]       reload_r;
    logic [WIDTH-1:0]       start_value_s;
    logic                   mode_r;
    logic                   mode_nxt_s;
    logic                   expire_s;

    // Registered outputs
    logic                   running_r;
    logic                   running_nxt_s;
    logic                   expired_r;
    logic                   flag_r;
    logic                   flag_nxt_s;
`ifdef TICK_TIMER_MISSED_EN
    logic [7:0]             missed_r;
    logic [7:0]             missed_nxt_s;
`endif

    // Synchronise slowClock, delay it one cycle and register its rising edge as tick
    always_ff @(posedge sourceClock) begin
        if (reset) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            delay_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], slowClock};
            delay_r <= sync_r[SYNC_STAGES-1];
            tick_r  <= sync_r[SYNC_STAGES-1] & ~delay_r;
        end
    end

    // State register together with the count, mode and reload registers
    always_ff @(posedge sourceClock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            mode_r   <= 1'b0;
            reload_r <= CNT_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            mode_r   <= mode_nxt_s;
            if (load) begin
                reload_r <= loadValue;
            end else begin
                reload_r <= reload_r;
            end
        end
    end

    // Next-state logic: stop beats start, start beats tick-driven decrement
    always_comb begin
        // A same-cycle load feeds start directly, bypassing the reload register
        start_value_s = load ? loadValue : reload_r;
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        mode_nxt_s    = mode_r;
        expire_s      = 1'b0;
        if (stop) begin
            state_nxt_s = ST_IDLE;
            count_nxt_s = CNT_ZERO;
        end else if (start && (start_value_s != CNT_ZERO)) begin
            // Accepted start (also restarts a running count); a zero start value is ignored
            state_nxt_s = ST_RUNNING;
            count_nxt_s = start_value_s;
            mode_nxt_s  = periodic;
        end else begin
            case (state_r)
                ST_RUNNING: begin
                    if (tick_r && (count_r == CNT_ONE)) begin
                        expire_s = 1'b1;
                        if (mode_r) begin
                            count_nxt_s = reload_r;
                        end else begin
                            count_nxt_s = CNT_ZERO;
                            state_nxt_s = ST_DONE;
                        end
                    end else if (tick_r && (count_r != CNT_ZERO)) begin
                        count_nxt_s = count_r - CNT_ONE;
                    end else begin
                        // Count of zero in RUNNING (periodic reload of 0) never wraps
                        count_nxt_s = count_r;
                    end
                end
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Output logic: next values of running, sticky flag (set wins over ack) and missed counter
    always_comb begin
        running_nxt_s = (state_nxt_s == ST_RUNNING);
        if (expire_s) begin
            flag_nxt_s = 1'b1;
        end else if (ack) begin
            flag_nxt_s = 1'b0;
        end else begin
            flag_nxt_s = flag_r;
        end
`ifdef TICK_TIMER_MISSED_EN
        if (ack) begin
            missed_nxt_s = 8'd0;
        end else if (expire_s && flag_r && (missed_r != 8'hFF)) begin
            missed_nxt_s = missed_r + 8'd1;
        end else begin
            missed_nxt_s = missed_r;
        end
`endif
    end

    // Output registers
    always_ff @(posedge sourceClock) begin
        if (reset) begin
            running_r <= 1'b0;
            expired_r <= 1'b0;
            flag_r    <= 1'b0;
`ifdef TICK_TIMER_MISSED_EN
            missed_r  <= 8'd0;
`endif
        end else begin
            running_r <= running_nxt_s;
            expired_r <= expire_s;
            flag_r    <= flag_nxt_s;
`ifdef TICK_TIMER_MISSED_EN
            missed_r  <= missed_nxt_s;
`endif
        end
    end

    assign tick        = tick_r;
    assign count       = count_r;
    assign running     = running_r;
    assign expired     = expired_r;
    assign expiredFlag = flag_r;
`ifdef TICK_TIMER_MISSED_EN
    assign missedCount = missed_r;
`endif

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural reference model.
module tb_tick_timer;

    localparam int WIDTH = 16;
    localparam int SYNC  = 2;

    logic             sourceClock = 1'b0;
    logic             reset       = 1'b1;
    logic             slowClock   = 1'b0;
    logic             load        = 1'b0;
    logic [WIDTH-1:0] loadValue   = '0;
    logic             start       = 1'b0;
    logic             stop        = 1'b0;
    logic             periodic    = 1'b0;
    logic             ack         = 1'b0;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;
    logic             expiredFlag;
`ifdef TICK_TIMER_MISSED_EN
    logic [7:0]       missedCount;
`endif

    tick_timer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .sourceClock (sourceClock),
        .reset       (reset),
        .slowClock   (slowClock),
        .load        (load),
        .loadValue   (loadValue),
        .start       (start),
        .stop        (stop),
        .periodic    (periodic),
        .ack         (ack),
        .tick        (tick),
        .count       (count),
        .running     (running),
        .expired     (expired),
        .expiredFlag (expiredFlag)
`ifdef TICK_TIMER_MISSED_EN
        ,
        .missedCount (missedCount)
`endif
    );

    // Free-running system clock
    always #5 sourceClock = ~sourceClock;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int exp_seen     = 0;
    int tick_seen    = 0;

    // Reference model: state 0 = idle, 1 = running, 2 = done
    int          m_state  = 0;
    int unsigned m_count  = 0;
    int unsigned m_reload = 0;
    bit          m_mode   = 0;
    bit          m_flag   = 0;
    bit          m_exp    = 0;
    bit          m_tick   = 0;
    int          m_missed = 0;
    bit          hist[$];     // slowClock value sampled at each edge

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock edge: update the model from the inputs seen at that edge, then compare
    task automatic step();
        bit          t_prev;
        bit          fire;
        bit          flag_old;
        int unsigned sv;
        int          n;
        @(posedge sourceClock);
        cyc++;
        hist.push_back(slowClock);
        if (hist.size() > 16) void'(hist.pop_front());
        n      = hist.size();
        t_prev = m_tick;
        if (reset) begin
            m_state = 0; m_count = 0; m_reload = 0; m_mode = 0;
            m_flag = 0; m_exp = 0; m_tick = 0; m_missed = 0;
            for (int k = 0; k <= SYNC; k++) hist[n-1-k] = 1'b0;
        end else begin
            sv       = load ? int'(loadValue) : m_reload;
            fire     = 0;
            flag_old = m_flag;
            if (stop) begin
                m_state = 0; m_count = 0;
            end else if (start && sv != 0) begin
                m_state = 1; m_count = sv; m_mode = periodic;
            end else if (m_state == 1 && t_prev && m_count > 0) begin
                if (m_count == 1) begin
                    fire = 1;
                    if (m_mode) m_count = m_reload;
                    else begin m_count = 0; m_state = 2; end
                end else begin
                    m_count = m_count - 1;
                end
            end
            m_exp = fire;
            if (fire) m_flag = 1; else if (ack) m_flag = 0;
            if (ack) m_missed = 0;
            else if (fire && flag_old && m_missed < 255) m_missed++;
            if (load) m_reload = loadValue;
            // rising edge of the sample taken SYNC edges ago
            m_tick = hist[n-1-SYNC] && !hist[n-2-SYNC];
        end
        #1;
        if (expired === 1'b1) exp_seen++;
        if (tick === 1'b1) tick_seen++;
        check_val("tick", 32'(tick), 32'(m_tick));
        check_val("count", 32'(count), m_count);
        check_val("running", 32'(running), 32'(m_state == 1));
        check_val("expired", 32'(expired), 32'(m_exp));
        check_val("expiredFlag", 32'(expiredFlag), 32'(m_flag));
`ifdef TICK_TIMER_MISSED_EN
        check_val("missedCount", 32'(missedCount), 32'(m_missed));
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One slowClock period (3 high, 3 low); the resulting count update lands inside it
    task automatic slow_tick();
        slowClock = 1'b1; steps(3);
        slowClock = 1'b0; steps(3);
    endtask

    task automatic do_load(input int unsigned v);
        load = 1'b1; loadValue = WIDTH'(v); step(); load = 1'b0;
    endtask

    task automatic do_start(input bit per);
        start = 1'b1; periodic = per; step(); start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < SYNC + 3; i++) hist.push_back(1'b0);

        // Reset for two cycles
        steps(2);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_running", 32'(running), 32'd0);
        reset = 1'b0;

        // Edge latency: slowClock goes high during cycle 10, tick in cycle 13 only
        while (cyc < 10) step();
        slowClock = 1'b1;
        steps(2);
        check_val("lat_tick12", 32'(tick), 32'd0);
        step();
        check_val("lat_tick13", 32'(tick), 32'd1);
        step();
        check_val("lat_tick14", 32'(tick), 32'd0);
        tick_seen = 0;
        steps(20);
        check_val("lat_no_more_ticks", 32'(tick_seen), 32'd0);
        slowClock = 1'b0; steps(4);

        // One-shot of 5 ticks
        do_load(5);
        do_start(1'b0);
        check_val("os_count_start", 32'(count), 32'd5);
        exp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            slow_tick();
            check_val("os_count_step", 32'(count), 32'(4 - i));
        end
        check_val("os_expired_once", 32'(exp_seen), 32'd1);
        check_val("os_running", 32'(running), 32'd0);
        check_val("os_flag", 32'(expiredFlag), 32'd1);
        slow_tick();
        check_val("os_6th_count", 32'(count), 32'd0);
        check_val("os_6th_expired", 32'(exp_seen), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        check_val("ack_clear", 32'(expiredFlag), 32'd0);

        // Periodic, reload 3, nine ticks: three expiries, unacked
        do_load(3);
        do_start(1'b1);
        exp_seen = 0;
        for (int i = 0; i < 9; i++) slow_tick();
        check_val("per_expiries", 32'(exp_seen), 32'd3);
        check_val("per_count", 32'(count), 32'd3);
        check_val("per_running", 32'(running), 32'd1);
`ifdef TICK_TIMER_MISSED_EN
        check_val("missed_two", 32'(missedCount), 32'd2);
`endif
        ack = 1'b1; step(); ack = 1'b0;
`ifdef TICK_TIMER_MISSED_EN
        check_val("missed_ack", 32'(missedCount), 32'd0);
`endif

        // ack coincident with an expiry: set wins
        do_load(1);
        do_start(1'b1);
        slowClock = 1'b1; steps(3);
        ack = 1'b1; step(); ack = 1'b0;
        check_val("ack_exp_pulse", 32'(expired), 32'd1);
        check_val("ack_exp_flag", 32'(expiredFlag), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;
        check_val("ack_alone", 32'(expiredFlag), 32'd0);
        slowClock = 1'b0; steps(3);

        // stop coincident with the final tick
        do_load(2);
        do_start(1'b0);
        slow_tick();
        check_val("stop_pre_count", 32'(count), 32'd1);
        exp_seen = 0;
        slowClock = 1'b1; steps(3);
        stop = 1'b1; step(); stop = 1'b0;
        check_val("stop_no_exp", 32'(exp_seen), 32'd0);
        check_val("stop_count", 32'(count), 32'd0);
        check_val("stop_running", 32'(running), 32'd0);
        slowClock = 1'b0; steps(3);

        // load and start in the same cycle
        load = 1'b1; loadValue = 16'd7; start = 1'b1; periodic = 1'b0;
        step();
        load = 1'b0; start = 1'b0;
        check_val("load_start_count", 32'(count), 32'd7);
        stop = 1'b1; step(); stop = 1'b0;

        // start with reload 0 is ignored
        do_load(0);
        do_start(1'b0);
        check_val("zero_start_running", 32'(running), 32'd0);

        // all-ones reload is legal
        do_load(32'hFFFF);
        do_start(1'b0);
        slow_tick();
        check_val("max_count", 32'(count), 32'hFFFE);

        // Reset mid-count at count 2
        do_load(4);
        do_start(1'b0);
        slow_tick(); slow_tick();
        check_val("mid_pre_count", 32'(count), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        check_val("mid_count", 32'(count), 32'd0);
        check_val("mid_running", 32'(running), 32'd0);
        check_val("mid_expired", 32'(expired), 32'd0);

        // Random phase, checked every cycle against the model
        begin
            int slow_left = 3;
            for (int i = 0; i < 3000; i++) begin
                if (slow_left == 0) begin
                    slowClock = ~slowClock;
                    slow_left = $urandom_range(2, 6);
                end
                slow_left--;
                load      = ($urandom_range(0, 15) == 0);
                loadValue = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
                start     = ($urandom_range(0, 19) == 0);
                stop      = ($urandom_range(0, 63) == 0);
                ack       = ($urandom_range(0, 15) == 0);
                periodic  = $urandom_range(0, 1) == 1;
                reset     = ($urandom_range(0, 499) == 0);
                step();
            end
            load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0; reset = 1'b0;
            steps(4);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
